// File: rtl/ldst_access_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ldst_access_ctrl_pkg                                             |
// | Shared state, access-order and load-mask encodings for LDST.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package ldst_access_ctrl_pkg;

  typedef enum logic [2:0] {
    stateIdle    = 3'd0,
    stateReq     = 3'd1,
    stateWait    = 3'd2,
    stateDiscard = 3'd3,
    stateOut     = 3'd4
  } ldstState_t;

  localparam logic [1:0] c_orderByte = 2'd0;
  localparam logic [1:0] c_orderHalf = 2'd1;
  localparam logic [1:0] c_orderWord = 2'd2;
  localparam logic [1:0] c_orderRsvd = 2'd3;

  localparam logic [1:0] c_maskByte = 2'd0;
  localparam logic [1:0] c_maskHalf = 2'd1;
  localparam logic [1:0] c_maskWord = 2'd2;

  function automatic logic isMisaligned(input logic [1:0] order, input logic [1:0] addrLo);
    return (order == c_orderRsvd) ||
           ((order == c_orderHalf) && addrLo[0]) ||
           ((order == c_orderWord) && (addrLo != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ldst_lane_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ldst_lane_align                                                  |
// | Byte-lane enables, store-data lane placement and load alignment. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ldst_lane_align
  import ldst_access_ctrl_pkg::*;
(
  input  logic [1:0]  i_addrLo,
  input  logic [1:0]  i_order,
  input  logic [31:0] i_storeData,
  input  logic [31:0] i_loadWord,
  input  logic [1:0]  i_loadShift,
  input  logic [1:0]  i_loadMask,
  output logic [3:0]  o_byteEna,
  output logic [31:0] o_writeData,
  output logic [31:0] o_loadData
);

  logic [31:0] w_loadMask;

  always_comb begin
    o_byteEna   = 4'b0000;
    o_writeData = 32'd0;
    unique case (i_order)
      c_orderByte: begin
        o_byteEna   = 4'b0001 << i_addrLo;
        o_writeData = {24'd0, i_storeData[7:0]} << {i_addrLo, 3'b000};
      end
      c_orderHalf: begin
        o_byteEna   = 4'b0011 << {i_addrLo[1], 1'b0};
        o_writeData = {16'd0, i_storeData[15:0]} << {i_addrLo[1], 4'b0000};
      end
      c_orderWord: begin
        o_byteEna   = 4'b1111;
        o_writeData = i_storeData;
      end
      default: begin
        o_byteEna   = 4'b0000;
        o_writeData = 32'd0;
      end
    endcase
  end

  always_comb begin
    w_loadMask = 32'hFFFF_FFFF;
    unique case (i_loadMask)
      c_maskByte: w_loadMask = 32'h0000_00FF;
      c_maskHalf: w_loadMask = 32'h0000_FFFF;
      default:    w_loadMask = 32'hFFFF_FFFF;
    endcase
  end

  assign o_loadData = (i_loadWord >> {i_loadShift, 3'b000}) & w_loadMask;

endmodule
`default_nettype wire

// File: rtl/ldst_access_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ldst_access_ctrl                                                 |
// | Single-outstanding LDST request stage between execute and dmem.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ldst_access_ctrl
  import ldst_access_ctrl_pkg::*;
(
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iFLUSH,
  input  logic        iPREV_VALID,
  output logic        oPREV_LOCK,
  input  logic        iPREV_RW,
  input  logic [31:0] iPREV_ADDR,
  input  logic [31:0] iPREV_DATA,
  input  logic [1:0]  iPREV_ORDER,
  input  logic [1:0]  iPREV_LOAD_SHIFT,
  input  logic [1:0]  iPREV_LOAD_MASK,
  input  logic [4:0]  iPREV_DEST,
  output logic        oDATAIO_REQ,
  input  logic        iDATAIO_BUSY,
  output logic        oDATAIO_RW,
  output logic [31:0] oDATAIO_ADDR,
  output logic [3:0]  oDATAIO_BYTEENA,
  output logic [31:0] oDATAIO_DATA,
  input  logic        iDATAIO_VALID,
  input  logic [31:0] iDATAIO_DATA,
  output logic        oNEXT_VALID,
  input  logic        iNEXT_LOCK,
  output logic        oNEXT_WRITEBACK,
  output logic        oNEXT_FAULT,
  output logic [4:0]  oNEXT_DEST,
  output logic [31:0] oNEXT_DATA
);

  ldstState_t  r_state;
  ldstState_t  w_stateNext;

  logic        r_rw;
  logic [31:0] r_addr;
  logic [31:0] r_storeData;
  logic [1:0]  r_order;
  logic [1:0]  r_loadShift;
  logic [1:0]  r_loadMask;
  logic [4:0]  r_dest;
  logic        r_fault;
  logic [31:0] r_nextData;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_inReq;
  logic        w_inOut;
  logic [3:0]  w_byteEna;
  logic [31:0] w_writeData;
  logic [31:0] w_alignedLoad;

  assign w_accept     = iPREV_VALID && (r_state == stateIdle) && !iFLUSH;
  assign w_misaligned = isMisaligned(iPREV_ORDER, iPREV_ADDR[1:0]);

  ldst_lane_align u_laneAlign (
    .i_addrLo    (r_addr[1:0]),
    .i_order     (r_order),
    .i_storeData (r_storeData),
    .i_loadWord  (iDATAIO_DATA),
    .i_loadShift (r_loadShift),
    .i_loadMask  (r_loadMask),
    .o_byteEna   (w_byteEna),
    .o_writeData (w_writeData),
    .o_loadData  (w_alignedLoad)
  );

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_state <= stateIdle;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      stateIdle: begin
        if (w_accept) begin
          w_stateNext = w_misaligned ? stateOut : stateReq;
        end
      end
      stateReq: begin
        // Once the handshake completes the read is in flight, so a flushed load must drain.
        if (!iDATAIO_BUSY) begin
          if (r_rw) begin
            w_stateNext = iFLUSH ? stateIdle : stateOut;
          end else begin
            w_stateNext = iFLUSH ? stateDiscard : stateWait;
          end
        end else if (iFLUSH) begin
          w_stateNext = stateIdle;
        end
      end
      stateWait: begin
        // A flush coinciding with the response has nothing left to drain.
        if (iDATAIO_VALID) begin
          w_stateNext = iFLUSH ? stateIdle : stateOut;
        end else if (iFLUSH) begin
          w_stateNext = stateDiscard;
        end
      end
      stateDiscard: begin
        if (iDATAIO_VALID) begin
          w_stateNext = stateIdle;
        end
      end
      stateOut: begin
        if (iFLUSH || !iNEXT_LOCK) begin
          w_stateNext = stateIdle;
        end
      end
      default: begin
        w_stateNext = stateIdle;
      end
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_rw        <= 1'b0;
      r_addr      <= 32'd0;
      r_storeData <= 32'd0;
      r_order     <= 2'd0;
      r_loadShift <= 2'd0;
      r_loadMask  <= 2'd0;
      r_dest      <= 5'd0;
      r_fault     <= 1'b0;
      r_nextData  <= 32'd0;
    end else begin
      if (w_accept) begin
        r_rw        <= iPREV_RW;
        r_addr      <= iPREV_ADDR;
        r_storeData <= iPREV_DATA;
        r_order     <= iPREV_ORDER;
        r_loadShift <= iPREV_LOAD_SHIFT;
        r_loadMask  <= iPREV_LOAD_MASK;
        r_dest      <= iPREV_DEST;
        r_fault     <= w_misaligned;
        r_nextData  <= 32'd0;
      end else if ((r_state == stateWait) && iDATAIO_VALID && !iFLUSH) begin
        r_nextData <= w_alignedLoad;
      end
    end
  end

  assign w_inReq = (r_state == stateReq);
  assign w_inOut = (r_state == stateOut);

  assign oPREV_LOCK      = (r_state != stateIdle);
  assign oDATAIO_REQ     = w_inReq;
  assign oDATAIO_RW      = w_inReq && r_rw;
  assign oDATAIO_ADDR    = w_inReq ? {r_addr[31:2], 2'b00} : 32'd0;
  assign oDATAIO_BYTEENA = w_inReq ? w_byteEna : 4'd0;
  assign oDATAIO_DATA    = w_inReq ? w_writeData : 32'd0;
  assign oNEXT_VALID     = w_inOut;
  assign oNEXT_WRITEBACK = w_inOut && !r_rw && !r_fault;
  assign oNEXT_FAULT     = w_inOut && r_fault;
  assign oNEXT_DEST      = w_inOut ? r_dest : 5'd0;
  assign oNEXT_DATA      = w_inOut ? r_nextData : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_ldst_access_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ldst_access_ctrl                                              |
// | Scoreboard bench: directed scenarios plus randomized traffic.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_ldst_access_ctrl;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iFLUSH = 1'b0;
  logic        iPREV_VALID = 1'b0;
  logic        oPREV_LOCK;
  logic        iPREV_RW = 1'b0;
  logic [31:0] iPREV_ADDR = 32'd0;
  logic [31:0] iPREV_DATA = 32'd0;
  logic [1:0]  iPREV_ORDER = 2'd0;
  logic [1:0]  iPREV_LOAD_SHIFT = 2'd0;
  logic [1:0]  iPREV_LOAD_MASK = 2'd0;
  logic [4:0]  iPREV_DEST = 5'd0;
  logic        oDATAIO_REQ;
  logic        iDATAIO_BUSY = 1'b0;
  logic        oDATAIO_RW;
  logic [31:0] oDATAIO_ADDR;
  logic [3:0]  oDATAIO_BYTEENA;
  logic [31:0] oDATAIO_DATA;
  logic        iDATAIO_VALID = 1'b0;
  logic [31:0] iDATAIO_DATA = 32'd0;
  logic        oNEXT_VALID;
  logic        iNEXT_LOCK = 1'b0;
  logic        oNEXT_WRITEBACK;
  logic        oNEXT_FAULT;
  logic [4:0]  oNEXT_DEST;
  logic [31:0] oNEXT_DATA;

  ldst_access_ctrl dut (
    .iCLOCK          (iCLOCK),
    .inRESET         (inRESET),
    .iFLUSH          (iFLUSH),
    .iPREV_VALID     (iPREV_VALID),
    .oPREV_LOCK      (oPREV_LOCK),
    .iPREV_RW        (iPREV_RW),
    .iPREV_ADDR      (iPREV_ADDR),
    .iPREV_DATA      (iPREV_DATA),
    .iPREV_ORDER     (iPREV_ORDER),
    .iPREV_LOAD_SHIFT(iPREV_LOAD_SHIFT),
    .iPREV_LOAD_MASK (iPREV_LOAD_MASK),
    .iPREV_DEST      (iPREV_DEST),
    .oDATAIO_REQ     (oDATAIO_REQ),
    .iDATAIO_BUSY    (iDATAIO_BUSY),
    .oDATAIO_RW      (oDATAIO_RW),
    .oDATAIO_ADDR    (oDATAIO_ADDR),
    .oDATAIO_BYTEENA (oDATAIO_BYTEENA),
    .oDATAIO_DATA    (oDATAIO_DATA),
    .iDATAIO_VALID   (iDATAIO_VALID),
    .iDATAIO_DATA    (iDATAIO_DATA),
    .oNEXT_VALID     (oNEXT_VALID),
    .iNEXT_LOCK      (iNEXT_LOCK),
    .oNEXT_WRITEBACK (oNEXT_WRITEBACK),
    .oNEXT_FAULT     (oNEXT_FAULT),
    .oNEXT_DEST      (oNEXT_DEST),
    .oNEXT_DATA      (oNEXT_DATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] word;
  } memExp_t;

  typedef struct {
    logic        fault;
    logic        wb;
    logic [4:0]  dest;
    logic [31:0] data;
  } outExp_t;

  memExp_t     memExpQ[$];
  outExp_t     outExpQ[$];
  logic [31:0] memWords [256];

  int nCompared   = 0;
  int nMismatched = 0;
  int nHandshake  = 0;
  int pendingCnt  = 0;
  logic [31:0] pendingWord = 32'd0;
  int busyPct = 0, lockPct = 0, forceBusy = 0;
  int memLatMin = 1, memLatMax = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s actual=0x%08h required=0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  // Load result: take the bytes starting at 'shift', as many as the mask width, zero-filled.
  function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [1:0] shift,
                                            input logic [1:0] mask);
    int width = (mask == 2'd0) ? 1 : (mask == 2'd1) ? 2 : 4;
    logic [31:0] r = 32'd0;
    for (int k = 0; k < width; k++) begin
      if (int'(shift) + k < 4) r[8*k +: 8] = word[8*(int'(shift) + k) +: 8];
    end
    return r;
  endfunction

  function automatic bit modelFault(input logic [1:0] order, input logic [31:0] addr);
    if (order == 2'd3) return 1'b1;
    if (order == 2'd1) return (addr % 2) != 0;
    if (order == 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  task automatic pushExpected(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                              input logic [1:0] order, input logic [1:0] shift,
                              input logic [1:0] mask, input logic [4:0] dest, input bit expectOut);
    memExp_t m;
    outExp_t o;
    int size, off;
    bit f = modelFault(order, addr);
    if (!f) begin
      size = (order == 2'd0) ? 1 : (order == 2'd1) ? 2 : 4;
      off  = (order == 2'd2) ? 0 : int'(addr % 4);
      m.rw = rw; m.addr = addr & 32'hFFFF_FFFC; m.be = 4'd0; m.wd = 32'd0;
      m.word = memWords[addr[9:2]];
      for (int k = 0; k < size; k++) begin
        m.be[off + k] = 1'b1;
        m.wd[8*(off + k) +: 8] = data[8*k +: 8];
      end
      memExpQ.push_back(m);
    end
    if (expectOut) begin
      o.fault = f;
      o.wb    = !f && !rw;
      o.dest  = dest;
      o.data  = (!f && !rw) ? modelLoad(memWords[addr[9:2]], shift, mask) : 32'd0;
      outExpQ.push_back(o);
    end
  endtask

  task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] order, input logic [1:0] shift, input logic [1:0] mask,
                       input logic [4:0] dest, input bit expectOut);
    int waitCyc = 0;
    bit done = 1'b0;
    @(posedge iCLOCK); #1;
    iPREV_VALID = 1'b1; iPREV_RW = rw; iPREV_ADDR = addr; iPREV_DATA = data;
    iPREV_ORDER = order; iPREV_LOAD_SHIFT = shift; iPREV_LOAD_MASK = mask; iPREV_DEST = dest;
    while (!done) begin
      @(negedge iCLOCK);
      if (!oPREV_LOCK && !iFLUSH) begin
        done = 1'b1;
        pushExpected(rw, addr, data, order, shift, mask, dest, expectOut);
      end else if (++waitCyc > 200) begin
        done = 1'b1;
        check("accept_timeout", 32'd0, 32'd1);
      end
    end
    @(posedge iCLOCK); #1;
    iPREV_VALID = 1'b0;
  endtask

  task automatic waitIdle();
    bit idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge iCLOCK);
      idle = !oPREV_LOCK && outExpQ.size() == 0 && memExpQ.size() == 0 && pendingCnt == 0;
    end
    if (!idle) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Memory and writeback side drivers, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge iCLOCK); #1;
      iDATAIO_VALID = 1'b0;
      if (pendingCnt > 0) begin
        pendingCnt--;
        if (pendingCnt == 0) begin
          iDATAIO_VALID = 1'b1;
          iDATAIO_DATA  = pendingWord;
        end
      end
      if (forceBusy > 0 && oDATAIO_REQ) begin
        iDATAIO_BUSY = 1'b1;
        forceBusy--;
      end else begin
        iDATAIO_BUSY = (busyPct > 0) && (int'($urandom_range(99, 0)) < busyPct);
      end
      iNEXT_LOCK = (lockPct > 0) && (int'($urandom_range(99, 0)) < lockPct);
    end
  end

  // Memory request monitor.
  initial begin
    memExp_t e;
    forever begin
      @(negedge iCLOCK);
      if (inRESET && oDATAIO_REQ && !iDATAIO_BUSY) begin
        nHandshake++;
        if (memExpQ.size() == 0) begin
          nCompared++; nMismatched++;
          $display("FAIL unexpected_mem_req actual=addr 0x%08h required=no request", oDATAIO_ADDR);
        end else begin
          e = memExpQ.pop_front();
          check("mem_rw", {31'd0, oDATAIO_RW}, {31'd0, e.rw});
          check("mem_addr", oDATAIO_ADDR, e.addr);
          check("mem_byteena", {28'd0, oDATAIO_BYTEENA}, {28'd0, e.be});
          if (e.rw) check("mem_wdata", oDATAIO_DATA, e.wd);
          else begin
            pendingWord = e.word;
            pendingCnt  = int'($urandom_range(memLatMax, memLatMin));
          end
        end
      end
    end
  end

  // Writeback result monitor.
  initial begin
    outExp_t o;
    forever begin
      @(negedge iCLOCK);
      if (oNEXT_VALID && !iNEXT_LOCK) begin
        if (outExpQ.size() == 0) begin
          nCompared++; nMismatched++;
          $display("FAIL unexpected_next_valid actual=1 required=0 dest=%0d", oNEXT_DEST);
        end else begin
          o = outExpQ.pop_front();
          check("next_fault", {31'd0, oNEXT_FAULT}, {31'd0, o.fault});
          check("next_writeback", {31'd0, oNEXT_WRITEBACK}, {31'd0, o.wb});
          check("next_dest", {27'd0, oNEXT_DEST}, {27'd0, o.dest});
          check("next_data", oNEXT_DATA, o.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit flag;
    int hs0;
    for (int i = 0; i < 256; i++) memWords[i] = $urandom;
    memWords[0] = 32'hBEEF_1234;

    // Reset state.
    repeat (3) @(posedge iCLOCK);
    #1;
    check("reset_outputs", {29'd0, oPREV_LOCK, oDATAIO_REQ, oNEXT_VALID}, 32'd0);
    check("reset_addr_data", oDATAIO_ADDR | oNEXT_DATA | oDATAIO_DATA, 32'd0);
    inRESET = 1'b1;

    // ST8 at 0x1003: valid two cycles after accept.
    issue(1'b1, 32'h0000_1003, 32'h0000_00AB, 2'd0, 2'd0, 2'd0, 5'd3, 1'b1);
    @(negedge iCLOCK);
    check("st8_req_t1", {30'd0, oDATAIO_REQ, oNEXT_VALID}, 32'd2);
    @(negedge iCLOCK);
    check("st8_valid_t2", {31'd0, oNEXT_VALID}, 32'd1);
    waitIdle();

    // LD16 at 0x2002, shift 2, mask half: valid three cycles after accept.
    issue(1'b0, 32'h0000_2002, 32'd0, 2'd1, 2'd2, 2'd1, 5'd9, 1'b1);
    @(negedge iCLOCK);
    @(negedge iCLOCK);
    check("ld16_not_valid_t2", {31'd0, oNEXT_VALID}, 32'd0);
    @(negedge iCLOCK);
    check("ld16_valid_t3", {31'd0, oNEXT_VALID}, 32'd1);
    check("ld16_data", oNEXT_DATA, 32'h0000_BEEF);
    waitIdle();

    // LD32 with memory busy for three REQ cycles.
    forceBusy = 3;
    issue(1'b0, 32'h0000_5004, 32'd0, 2'd2, 2'd0, 2'd2, 5'd17, 1'b1);
    hs0 = nHandshake;
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLOCK);
      check("busy_hold", {oDATAIO_REQ, oPREV_LOCK, oDATAIO_ADDR[29:0]}, {2'b11, 30'h0000_5004});
    end
    waitIdle();
    check("busy_one_handshake", nHandshake - hs0, 32'd1);

    // Misaligned LD32: fault with no memory request.
    issue(1'b0, 32'h0000_3002, 32'd0, 2'd2, 2'd0, 2'd2, 5'd5, 1'b1);
    flag = 1'b0;
    repeat (4) begin
      @(negedge iCLOCK);
      flag |= oDATAIO_REQ;
    end
    check("fault_no_req", {31'd0, flag}, 32'd0);
    waitIdle();

    // Flush during WAIT, late response dropped, then a fresh load.
    memLatMin = 3; memLatMax = 3;
    issue(1'b0, 32'h0000_4008, 32'd0, 2'd2, 2'd0, 2'd2, 5'd7, 1'b0);
    @(posedge iCLOCK); #1;
    iFLUSH = 1'b1;
    @(posedge iCLOCK); #1;
    iFLUSH = 1'b0;
    waitIdle();
    memLatMin = 1; memLatMax = 1;
    issue(1'b0, 32'h0000_400C, 32'd0, 2'd2, 2'd0, 2'd2, 5'd8, 1'b1);
    waitIdle();

    // Flush in REQ while memory is busy: nothing issued, nothing returned.
    forceBusy = 5;
    issue(1'b1, 32'h0000_6000, 32'h1234_5678, 2'd2, 2'd0, 2'd0, 5'd4, 1'b0);
    iFLUSH = 1'b1;
    @(posedge iCLOCK); #1;
    iFLUSH = 1'b0;
    forceBusy = 0;
    flag = 1'b0;
    repeat (3) begin
      @(negedge iCLOCK);
      flag |= oPREV_LOCK | oNEXT_VALID;
    end
    check("req_flush_idle", {31'd0, flag}, 32'd0);
    check("req_flush_no_handshake", memExpQ.size(), 32'd1);
    memExpQ.delete();

    // Reset during WAIT, then a stale response after release.
    memLatMin = 3; memLatMax = 3;
    issue(1'b0, 32'h0000_7010, 32'd0, 2'd2, 2'd0, 2'd2, 5'd11, 1'b0);
    @(posedge iCLOCK); #1;
    inRESET = 1'b0;
    #1;
    check("reset_wait_outputs", {29'd0, oPREV_LOCK, oDATAIO_REQ, oNEXT_VALID}, 32'd0);
    @(posedge iCLOCK); #1;
    inRESET = 1'b1;
    flag = 1'b0;
    repeat (5) begin
      @(negedge iCLOCK);
      flag |= oPREV_LOCK | oNEXT_VALID | oDATAIO_REQ;
    end
    check("reset_stale_quiet", {31'd0, flag}, 32'd0);
    waitIdle();

    // Randomized traffic with back-pressure on both sides.
    busyPct = 25; lockPct = 30; memLatMin = 1; memLatMax = 3;
    for (int n = 0; n < 80; n++) begin
      issue(1'($urandom), $urandom, $urandom, 2'($urandom), 2'($urandom), 2'($urandom),
            5'($urandom), 1'b1);
    end
    waitIdle();
    check("final_out_queue_empty", outExpQ.size(), 32'd0);
    check("final_mem_queue_empty", memExpQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
